// File: rtl/spike_event_decoder_pkg.sv
// spike_event_decoder_pkg: shared spike-network definitions used by the decoder and its encoder counterpart
//   net_state_t       : NETWORK-style FSM state encoding (IDLE / DRAIN / CLEAR)
//   EVT_ID_LSB        : bit position of the neuron ID inside a serialized event
//   evt_val_lsb/msb   : bit positions of the spike value (value sits above the ID)
//   DROP_CNT_W/MAX    : width and saturation value of the dropped-event counter
//   clamp_win         : clamps the active-neuron window width into [1, id_width]
package spike_event_decoder_pkg;

    typedef enum logic [1:0] {
        NET_IDLE  = 2'd0,
        NET_DRAIN = 2'd1,
        NET_CLEAR = 2'd2
    } net_state_t;

    localparam int EVT_ID_LSB = 0;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    function automatic int evt_val_lsb(input int id_width);
        return EVT_ID_LSB + id_width;
    endfunction

    function automatic int evt_val_msb(input int ten_width, input int id_width);
        return EVT_ID_LSB + id_width + ten_width - 1;
    endfunction

    // A zero-width window would admit no neuron at all, so it is treated as width 1;
    // anything wider than the ID field is meaningless and saturates at the ID width.
    function automatic logic [3:0] clamp_win(input logic [3:0] bits, input int id_width);
        if (bits == 4'd0)
            return 4'd1;
        if (int'(bits) > id_width)
            return 4'(id_width);
        return bits;
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: synchronous event FIFO with flush
//   clk, reset_l : clock and synchronous active-low reset
//   push, wdata  : write one entry (ignored when full)
//   pop          : remove the head entry (ignored when empty)
//   flush        : discard all entries
//   rdata        : current head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries
module spike_event_fifo
    import spike_event_decoder_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_l || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spike_event_decoder.sv
// spike_event_decoder: receives serialized spike events, buffers them and scatters values into a per-neuron state vector
//   clk, reset_l           : clock and synchronous active-low reset
//   top_en_network         : global enable, low freezes all state
//   evt_valid/evt_ready    : event handshake, evt_data = {value, id}
//   bits_in_active_neuron  : active ID window width, sampled when an event is applied
//   clear_req/clear_done   : zero spike_state and flush buffered events; clear_done marks the CLEAR cycle
//   spike_state            : neuron n at [n*TEN_DATA_WIDTH +: TEN_DATA_WIDTH]
//   drop_cnt               : saturating count of out-of-window events
// Build option: SPIKE_DECODER_DROP_CNT_EN enables the window check and drop counter;
// without it every event is applied using its full ID and drop_cnt reads 0.
module spike_event_decoder
    import spike_event_decoder_pkg::*;
#(
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 256,
    parameter int NEURON_ID_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_l,
    input  logic                                 top_en_network,
    input  logic                                 evt_valid,
    input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] evt_data,
    output logic                                 evt_ready,
    input  logic [3:0]                           bits_in_active_neuron,
    input  logic                                 clear_req,
    output logic                                 clear_done,
    output logic [TEN_DATA_WIDTH*NUM_NEURON-1:0] spike_state,
    output logic [DROP_CNT_W-1:0]                drop_cnt
);

    localparam int EW      = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int VAL_LSB = evt_val_lsb(NEURON_ID_WIDTH);

    net_state_t                 state;
    logic [EW-1:0]              head;
    logic                       full;
    logic                       empty;
    logic [CW-1:0]              count;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       drop;
    logic [NEURON_ID_WIDTH-1:0] head_id;
    logic [TEN_DATA_WIDTH-1:0]  head_val;

    assign head_id  = head[EVT_ID_LSB +: NEURON_ID_WIDTH];
    assign head_val = head[VAL_LSB +: TEN_DATA_WIDTH];

    // Ready never looks at evt_valid; a full FIFO refuses a push even if a pop happens this cycle.
    assign evt_ready  = reset_l & top_en_network & ~full & ~clear_req & (state != NET_CLEAR);
    assign clear_done = state == NET_CLEAR;
    assign push       = evt_valid & evt_ready;
    assign flush      = top_en_network & clear_req & (state != NET_CLEAR);
    // The head is not applied in the request cycle: the clear wipes spike_state at that edge anyway.
    assign pop        = top_en_network & (state == NET_DRAIN) & ~clear_req & ~empty;

    spike_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (push),
        .wdata   (evt_data),
        .pop     (pop),
        .flush   (flush),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

`ifdef SPIKE_DECODER_DROP_CNT_EN
    logic [3:0] win;

    // Window is evaluated on the head at pop time, so a width change affects already-buffered events.
    assign win  = clamp_win(bits_in_active_neuron, NEURON_ID_WIDTH);
    assign drop = (head_id >> win) != '0;

    always_ff @(posedge clk) begin
        if (!reset_l)
            drop_cnt <= '0;
        else if (pop && drop && drop_cnt != DROP_CNT_MAX)
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    logic unused_win;

    assign unused_win = ^bits_in_active_neuron;
    assign drop       = 1'b0;
    assign drop_cnt   = '0;
`endif

    // State mirrors FIFO occupancy: DRAIN exactly while entries are buffered.
    always_ff @(posedge clk) begin
        if (!reset_l)
            state <= NET_IDLE;
        else if (top_en_network) begin
            if (flush)
                state <= NET_CLEAR;
            else if (state == NET_CLEAR)
                state <= NET_IDLE;
            else if (push)
                state <= NET_DRAIN;
            else if (pop && count == CW'(1))
                state <= NET_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l || flush)
            spike_state <= '0;
        else if (pop && !drop)
            spike_state[head_id*TEN_DATA_WIDTH +: TEN_DATA_WIDTH] <= head_val;
    end

endmodule
